// File: rtl/issue_queue_pkg.sv
// Shared types and default sizing for the ALU issue queue and its dispatch interface.
package issue_queue_pkg;

    localparam int DISPATCH_WIDTH       = 2;
    localparam int PHYS_REGS_ADDR_WIDTH = 6;
    localparam int DEF_ISQ_DEPTH        = 8;
    localparam int DEF_WB_WIDTH         = 2;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_cmd_t;

    typedef enum logic [1:0] {
        OP_REG = 2'd0,
        OP_IMM = 2'd1,
        OP_PC  = 2'd2
    } op_type_t;

    typedef struct packed {
        logic                            valid;
        alu_cmd_t                        alu_cmd;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] op1;
        logic                            op1_rdy;
        logic [31:0]                     op2;
        op_type_t                        op2_type;
        logic                            op2_rdy;
        logic [PHYS_REGS_ADDR_WIDTH-1:0] phys_rd;
    } isq_entry_t;

    // Only register-typed op2 carries a tag that needs waking.
    function automatic logic op_is_reg(input op_type_t t);
        return t == OP_REG;
    endfunction

endpackage

// File: rtl/isq_dispatch_if.sv
// Rename -> issue dispatch bundle: DISPATCH_WIDTH lanes forward, full back.
interface isqDispatchIf;
    import issue_queue_pkg::*;

    logic [DISPATCH_WIDTH-1:0]                            en;
    alu_cmd_t [DISPATCH_WIDTH-1:0]                        alu_cmd;
    logic [DISPATCH_WIDTH-1:0]                            op1_valid;
    logic [DISPATCH_WIDTH-1:0]                            op2_valid;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  op1;
    logic [DISPATCH_WIDTH-1:0][31:0]                      op2;
    op_type_t [DISPATCH_WIDTH-1:0]                        op2_type;
    logic [DISPATCH_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  phys_rd;
    logic                                                 full;

    modport in  (input en, alu_cmd, op1_valid, op2_valid, op1, op2, op2_type, phys_rd,
                 output full);
    modport out (output en, alu_cmd, op1_valid, op2_valid, op1, op2, op2_type, phys_rd,
                 input full);

endinterface

// File: rtl/issue_queue_select.sv
// isq_select: one-hot pick of a ready entry; lowest index, or oldest when ISQ_AGE_SELECT_EN.
module isq_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            ready,
`ifdef ISQ_AGE_SELECT_EN
    input  logic [DEPTH-1:0][DEPTH-1:0] age,
`endif
    output logic [DEPTH-1:0]            grant,
    output logic                        grant_valid
);

`ifdef ISQ_AGE_SELECT_EN
    // age[j][i] = entry j is older than entry i; grant the ready entry nobody ready beats.
    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            logic blocked;
            blocked = 1'b0;
            for (int j = 0; j < DEPTH; j++) begin
                if (ready[j] && age[j][i]) blocked = 1'b1;
            end
            grant[i] = ready[i] && !blocked;
        end
    end
`else
    always_comb begin
        logic found;
        grant = '0;
        found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (ready[i] && !found) begin
                grant[i] = 1'b1;
                found    = 1'b1;
            end
        end
    end
`endif

    assign grant_valid = |ready;

endmodule

// File: rtl/issue_queue.sv
// issue_queue: buffers dispatched ALU ops, wakes operands on writeback tags, issues one per cycle.
// Define ISQ_AGE_SELECT_EN to issue the oldest ready entry instead of the lowest-index one.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int ISQ_DEPTH = DEF_ISQ_DEPTH,
    parameter int WB_WIDTH  = DEF_WB_WIDTH
) (
    input  logic                                           clk,
    input  logic                                           rst,
    isqDispatchIf.in                                       dispatch,
    input  logic                                           flush,
    input  logic [WB_WIDTH-1:0]                            wb_valid,
    input  logic [WB_WIDTH-1:0][PHYS_REGS_ADDR_WIDTH-1:0]  wb_phys_rd,
    output logic                                           issue_valid,
    input  logic                                           issue_ready,
    output alu_cmd_t                                       issue_alu_cmd,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                issue_op1,
    output logic [31:0]                                    issue_op2,
    output op_type_t                                       issue_op2_type,
    output logic [PHYS_REGS_ADDR_WIDTH-1:0]                issue_phys_rd
);

    localparam int PW = PHYS_REGS_ADDR_WIDTH;

    isq_entry_t [ISQ_DEPTH-1:0]                q;
    isq_entry_t [DISPATCH_WIDTH-1:0]           new_e;
    logic [ISQ_DEPTH-1:0]                      valid_vec;
    logic [ISQ_DEPTH-1:0]                      ready_vec;
    logic [ISQ_DEPTH-1:0]                      grant;
    logic [DISPATCH_WIDTH-1:0][ISQ_DEPTH-1:0]  alloc;
    logic                                      grant_valid;
    logic                                      kill;
    logic                                      issue_fire;
    logic [$bits(isq_entry_t)-1:0]             sel_bits;
    isq_entry_t                                sel_e;
    int                                        n_free;

    function automatic logic wb_hit(input logic [PW-1:0] tag);
        logic hit;
        hit = 1'b0;
        for (int p = 0; p < WB_WIDTH; p++) begin
            if (wb_valid[p] && (wb_phys_rd[p] == tag)) hit = 1'b1;
        end
        return hit;
    endfunction

    assign kill = rst || flush;

    always_comb begin
        valid_vec = '0;
        ready_vec = '0;
        n_free    = 0;
        for (int j = 0; j < ISQ_DEPTH; j++) begin
            valid_vec[j] = q[j].valid;
            ready_vec[j] = q[j].valid && q[j].op1_rdy && q[j].op2_rdy;
            if (!q[j].valid) n_free = n_free + 1;
        end
    end

    // Slots being issued this cycle are still counted as occupied.
    assign dispatch.full = (n_free < DISPATCH_WIDTH);

    // Each enabled lane takes the lowest free slot not already claimed by a lower lane.
    always_comb begin
        logic [ISQ_DEPTH-1:0] taken;
        logic                 found;
        taken = valid_vec;
        alloc = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            found = 1'b0;
            if (dispatch.en[l] && !dispatch.full) begin
                for (int j = 0; j < ISQ_DEPTH; j++) begin
                    if (!found && !taken[j]) begin
                        alloc[l][j] = 1'b1;
                        taken[j]    = 1'b1;
                        found       = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        new_e = '0;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            new_e[l].valid    = 1'b1;
            new_e[l].alu_cmd  = dispatch.alu_cmd[l];
            new_e[l].op1      = dispatch.op1[l];
            new_e[l].op1_rdy  = dispatch.op1_valid[l] || wb_hit(dispatch.op1[l]);
            new_e[l].op2      = dispatch.op2[l];
            new_e[l].op2_type = dispatch.op2_type[l];
            new_e[l].op2_rdy  = !op_is_reg(dispatch.op2_type[l]) || dispatch.op2_valid[l] ||
                                wb_hit(dispatch.op2[l][PW-1:0]);
            new_e[l].phys_rd  = dispatch.phys_rd[l];
        end
    end

`ifdef ISQ_AGE_SELECT_EN
    logic [ISQ_DEPTH-1:0][ISQ_DEPTH-1:0] age_q;
    logic [ISQ_DEPTH-1:0][ISQ_DEPTH-1:0] age_d;

    // A new entry is younger than everything held plus any lower lane of the same cycle.
    always_comb begin
        logic [ISQ_DEPTH-1:0] prior;
        age_d = age_q;
        prior = valid_vec;
        for (int l = 0; l < DISPATCH_WIDTH; l++) begin
            for (int k = 0; k < ISQ_DEPTH; k++) begin
                if (alloc[l][k]) begin
                    age_d[k] = '0;
                    for (int i = 0; i < ISQ_DEPTH; i++) age_d[i][k] = prior[i];
                end
            end
            prior = prior | alloc[l];
        end
        if (issue_fire) begin
            for (int k = 0; k < ISQ_DEPTH; k++) begin
                if (grant[k]) begin
                    age_d[k] = '0;
                    for (int i = 0; i < ISQ_DEPTH; i++) age_d[i][k] = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (kill) age_q <= '0;
        else      age_q <= age_d;
    end

    isq_select #(.DEPTH(ISQ_DEPTH)) u_select (
        .ready       (ready_vec),
        .age         (age_q),
        .grant       (grant),
        .grant_valid (grant_valid)
    );
`else
    isq_select #(.DEPTH(ISQ_DEPTH)) u_select (
        .ready       (ready_vec),
        .grant       (grant),
        .grant_valid (grant_valid)
    );
`endif

    assign issue_valid = grant_valid && !kill;
    assign issue_fire  = issue_valid && issue_ready;

    // One-hot AND-OR mux; payload reads as zero whenever nothing is offered.
    always_comb begin
        sel_bits = '0;
        for (int j = 0; j < ISQ_DEPTH; j++) begin
            if (grant[j] && !kill) sel_bits = sel_bits | q[j];
        end
    end

    assign sel_e          = isq_entry_t'(sel_bits);
    assign issue_alu_cmd  = sel_e.alu_cmd;
    assign issue_op1      = sel_e.op1;
    assign issue_op2      = sel_e.op2;
    assign issue_op2_type = sel_e.op2_type;
    assign issue_phys_rd  = sel_e.phys_rd;

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (flush) begin
            for (int j = 0; j < ISQ_DEPTH; j++) q[j].valid <= 1'b0;
        end else begin
            for (int j = 0; j < ISQ_DEPTH; j++) begin
                if (!q[j].op1_rdy && wb_hit(q[j].op1)) q[j].op1_rdy <= 1'b1;
                if (!q[j].op2_rdy && wb_hit(q[j].op2[PW-1:0])) q[j].op2_rdy <= 1'b1;
                if (issue_fire && grant[j]) q[j].valid <= 1'b0;
            end
            for (int l = 0; l < DISPATCH_WIDTH; l++) begin
                for (int j = 0; j < ISQ_DEPTH; j++) begin
                    if (alloc[l][j]) q[j] <= new_e[l];
                end
            end
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (!rst) begin
            assert (!((|dispatch.en) && dispatch.full))
                else $warning("issue_queue: dispatch while full dropped");
        end
    end
`endif

endmodule

// File: tb/tb_issue_queue.sv
// Bench for issue_queue: directed scenarios plus randomized traffic against a slot/sequence model.
module tb_issue_queue;
    import issue_queue_pkg::*;

    localparam int D  = DEF_ISQ_DEPTH;
    localparam int W  = DEF_WB_WIDTH;
    localparam int DW = DISPATCH_WIDTH;
    localparam int PW = PHYS_REGS_ADDR_WIDTH;

    logic clk = 1'b0;
    logic rst, flush, issue_ready, issue_valid;
    logic [W-1:0] wb_valid;
    logic [W-1:0][PW-1:0] wb_phys_rd;
    alu_cmd_t issue_alu_cmd;
    logic [PW-1:0] issue_op1, issue_phys_rd;
    logic [31:0] issue_op2;
    op_type_t issue_op2_type;

    isqDispatchIf disp();

    issue_queue #(.ISQ_DEPTH(D), .WB_WIDTH(W)) dut (
        .clk(clk), .rst(rst), .dispatch(disp), .flush(flush),
        .wb_valid(wb_valid), .wb_phys_rd(wb_phys_rd),
        .issue_valid(issue_valid), .issue_ready(issue_ready),
        .issue_alu_cmd(issue_alu_cmd), .issue_op1(issue_op1), .issue_op2(issue_op2),
        .issue_op2_type(issue_op2_type), .issue_phys_rd(issue_phys_rd)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: per-slot contents plus a dispatch sequence number for age.
    bit          m_v[D], m_r1[D], m_r2[D];
    logic [PW-1:0] m_t1[D], m_t2[D], m_rd[D];
    alu_cmd_t    m_cmd[D];
    logic [31:0] m_op2[D];
    op_type_t    m_ty[D];
    int          m_seq[D];
    int          seq_ctr = 0;

    function automatic bit wb_hit(input logic [PW-1:0] t);
        for (int p = 0; p < W; p++) if (wb_valid[p] && wb_phys_rd[p] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic int m_occ();
        int n = 0;
        for (int s = 0; s < D; s++) if (m_v[s]) n++;
        return n;
    endfunction

    function automatic bit m_full();
        return (D - m_occ()) < DW;
    endfunction

    function automatic int m_pick();
        int best = -1;
        for (int s = 0; s < D; s++) begin
            if (m_v[s] && m_r1[s] && m_r2[s]) begin
`ifdef ISQ_AGE_SELECT_EN
                if (best < 0 || m_seq[s] < m_seq[best]) best = s;
`else
                if (best < 0) best = s;
`endif
            end
        end
        return best;
    endfunction

    function automatic bit m_issue_valid();
        return !rst && !flush && (m_pick() >= 0);
    endfunction

    // Advance the model with the inputs currently applied, then cross the clock edge.
    task automatic step();
        bit full0, fire;
        int sel;
        bit taken[D];
        full0 = m_full();
        sel   = m_pick();
        fire  = m_issue_valid() && issue_ready;
        for (int s = 0; s < D; s++) taken[s] = m_v[s];
        if (rst || flush) begin
            for (int s = 0; s < D; s++) m_v[s] = 1'b0;
        end else begin
            for (int s = 0; s < D; s++) begin
                if (wb_hit(m_t1[s])) m_r1[s] = 1'b1;
                if (m_ty[s] == OP_REG && wb_hit(m_t2[s])) m_r2[s] = 1'b1;
            end
            if (fire) m_v[sel] = 1'b0;
            if (!full0) begin
                for (int l = 0; l < DW; l++) begin
                    if (!disp.en[l]) continue;
                    for (int s = 0; s < D; s++) begin
                        if (!taken[s]) begin
                            taken[s] = 1'b1;
                            m_v[s]   = 1'b1;
                            m_cmd[s] = disp.alu_cmd[l];
                            m_t1[s]  = disp.op1[l];
                            m_r1[s]  = disp.op1_valid[l] || wb_hit(disp.op1[l]);
                            m_op2[s] = disp.op2[l];
                            m_ty[s]  = disp.op2_type[l];
                            m_t2[s]  = disp.op2[l][PW-1:0];
                            m_r2[s]  = (disp.op2_type[l] != OP_REG) || disp.op2_valid[l] ||
                                       wb_hit(disp.op2[l][PW-1:0]);
                            m_rd[s]  = disp.phys_rd[l];
                            m_seq[s] = seq_ctr++;
                            break;
                        end
                    end
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic put_lane(input int l, input alu_cmd_t c, input logic [PW-1:0] t1, input bit v1,
                            input logic [31:0] o2, input op_type_t ty, input bit v2,
                            input logic [PW-1:0] rd);
        disp.alu_cmd[l] = c;  disp.op1[l] = t1;      disp.op1_valid[l] = v1;
        disp.op2[l] = o2;     disp.op2_type[l] = ty; disp.op2_valid[l] = v2;
        disp.phys_rd[l] = rd;
    endtask

    task automatic clear_in();
        disp.en = '0; flush = 1'b0; wb_valid = '0; wb_phys_rd = '0; issue_ready = 1'b0;
        for (int l = 0; l < DW; l++) put_lane(l, ALU_ADD, '0, 1'b0, 32'h0, OP_IMM, 1'b0, '0);
    endtask

    task automatic test_reset();
        for (int s = 0; s < D; s++) m_v[s] = 1'b0;
        clear_in();
        rst = 1'b1;
        issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_cycle_issue_valid got %b exp 0", issue_valid); end
        step(); step();
        rst = 1'b0; issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL reset_issue_valid got %b exp 0", issue_valid); end
        checks++; if (disp.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b exp 0", disp.full); end
        checks++; if (issue_op1 !== '0 || issue_op2 !== 32'h0 || issue_phys_rd !== '0)
            begin errors++; $display("FAIL reset_payload got op1=%0h op2=%0h rd=%0h exp 0", issue_op1, issue_op2, issue_phys_rd); end
    endtask

    task automatic test_imm();
        clear_in();
        put_lane(0, ALU_SUB, 6'd5, 1'b1, 32'h10, OP_IMM, 1'b0, 6'd11);
        disp.en = 2'b01;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL imm_same_cycle got %b exp 0", issue_valid); end
        step();
        disp.en = '0; issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL imm_issue_valid got %b exp 1", issue_valid); end
        checks++; if (issue_op2 !== 32'h10 || issue_op1 !== 6'd5 || issue_op2_type !== OP_IMM || issue_alu_cmd !== ALU_SUB)
            begin errors++; $display("FAIL imm_payload got op1=%0d op2=%0h exp op1=5 op2=10", issue_op1, issue_op2); end
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (issue_valid !== 1'b0 || disp.full !== 1'b0)
            begin errors++; $display("FAIL imm_empty got valid=%b full=%b exp 0 0", issue_valid, disp.full); end
    endtask

    task automatic test_wakeup();
        clear_in();
        put_lane(0, ALU_AND, 6'd7, 1'b0, 32'h3, OP_IMM, 1'b0, 6'd12);
        disp.en = 2'b01;
        #1; step();
        disp.en = '0;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_before got %b exp 0", issue_valid); end
        step();
        wb_valid = 2'b01; wb_phys_rd[0] = 6'd7;
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL wake_bcast_cycle got %b exp 0", issue_valid); end
        step();
        wb_valid = '0; issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_op1 !== 6'd7)
            begin errors++; $display("FAIL wake_after got valid=%b op1=%0d exp 1 7", issue_valid, issue_op1); end
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_dispatch_wakeup();
        clear_in();
        put_lane(0, ALU_OR, 6'd9, 1'b0, 32'h4, OP_IMM, 1'b0, 6'd13);
        disp.en = 2'b01; wb_valid = 2'b10; wb_phys_rd[1] = 6'd9;
        #1; step();
        clear_in(); issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_phys_rd !== 6'd13)
            begin errors++; $display("FAIL disp_wake got valid=%b rd=%0d exp 1 13", issue_valid, issue_phys_rd); end
        step();
        issue_ready = 1'b0;
    endtask

    task automatic test_full();
        int hs = 0;
        clear_in();
        for (int c = 0; c < 4; c++) begin
            disp.en = (c < 3) ? 2'b11 : 2'b01;
            for (int l = 0; l < DW; l++)
                put_lane(l, ALU_XOR, 6'(40 + 2*c + l), 1'b0, 32'h0, OP_IMM, 1'b0, 6'(32 + 2*c + l));
            #1;
            checks++; if (disp.full !== 1'b0) begin errors++; $display("FAIL fill_full_%0d got %b exp 0", c, disp.full); end
            step();
        end
        disp.en = 2'b11;
        put_lane(0, ALU_ADD, 6'd50, 1'b1, 32'h0, OP_IMM, 1'b0, 6'd50);
        put_lane(1, ALU_ADD, 6'd51, 1'b1, 32'h0, OP_IMM, 1'b0, 6'd51);
        #1;
        checks++; if (disp.full !== 1'b1) begin errors++; $display("FAIL full_at7 got %b exp 1", disp.full); end
        step();
        disp.en = '0; wb_valid = 2'b01; wb_phys_rd[0] = 6'd40;
        #1;
        checks++; if (disp.full !== 1'b1 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL full_hold got full=%b valid=%b exp 1 0", disp.full, issue_valid); end
        step();
        wb_valid = '0; issue_ready = 1'b1;
        #1;
        checks++; if (issue_valid !== 1'b1 || issue_phys_rd !== 6'd32 || disp.full !== 1'b1)
            begin errors++; $display("FAIL full_issue got valid=%b rd=%0d full=%b exp 1 32 1", issue_valid, issue_phys_rd, disp.full); end
        step();
        issue_ready = 1'b0;
        #1;
        checks++; if (disp.full !== 1'b0 || issue_valid !== 1'b0)
            begin errors++; $display("FAIL full_after_issue got full=%b valid=%b exp 0 0", disp.full, issue_valid); end
        issue_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            wb_valid = 2'b11; wb_phys_rd[0] = 6'(41 + 2*c); wb_phys_rd[1] = 6'(42 + 2*c);
            #1;
            if (issue_valid) hs++;
            checks++; if (issue_valid !== m_issue_valid()) begin errors++; $display("FAIL drain_bc_valid got %b exp %b", issue_valid, m_issue_valid()); end
            step();
        end
        wb_valid = '0;
        for (int c = 0; c < 12 && m_occ() > 0; c++) begin
            #1;
            if (issue_valid) hs++;
            checks++; if (issue_valid !== m_issue_valid()) begin errors++; $display("FAIL drain_valid got %b exp %b", issue_valid, m_issue_valid()); end
            if (m_pick() >= 0) begin
                checks++; if (issue_phys_rd !== m_rd[m_pick()]) begin errors++; $display("FAIL drain_rd got %0d exp %0d", issue_phys_rd, m_rd[m_pick()]); end
            end
            step();
        end
        #1;
        checks++; if (hs !== 6) begin errors++; $display("FAIL drain_count got %0d exp 6", hs); end
        checks++; if (issue_valid !== 1'b0 || disp.full !== 1'b0)
            begin errors++; $display("FAIL drain_empty got valid=%b full=%b exp 0 0", issue_valid, disp.full); end
        issue_ready = 1'b0;
    endtask

    task automatic test_flush();
        clear_in();
        disp.en = 2'b11;
        put_lane(0, ALU_ADD, 6'd1, 1'b1, 32'h1, OP_IMM, 1'b0, 6'd1);
        put_lane(1, ALU_ADD, 6'd2, 1'b1, 32'h2, OP_IMM, 1'b0, 6'd2);
        #1; step();
        disp.en = 2'b01;
        put_lane(0, ALU_ADD, 6'd3, 1'b1, 32'h3, OP_IMM, 1'b0, 6'd3);
        #1; step();
        disp.en = '0;
        #1;
        checks++; if (issue_valid !== 1'b1) begin errors++; $display("FAIL flush_pre got %b exp 1", issue_valid); end
        step();
        flush = 1'b1; issue_ready = 1'b1; disp.en = 2'b01;
        put_lane(0, ALU_ADD, 6'd4, 1'b1, 32'h4, OP_IMM, 1'b0, 6'd4);
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_cycle got %b exp 0", issue_valid); end
        step();
        clear_in();
        #1;
        checks++; if (issue_valid !== 1'b0 || disp.full !== 1'b0)
            begin errors++; $display("FAIL flush_after got valid=%b full=%b exp 0 0", issue_valid, disp.full); end
        step();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %b exp 0", issue_valid); end
    endtask

    task automatic test_age();
        logic [PW-1:0] exp_first, exp_second;
`ifdef ISQ_AGE_SELECT_EN
        exp_first = 6'h31; exp_second = 6'h32;
`else
        exp_first = 6'h32; exp_second = 6'h31;
`endif
        clear_in();
        disp.en = 2'b11;
        put_lane(0, ALU_ADD, 6'd19, 1'b1, 32'h0, OP_IMM, 1'b0, 6'h30);
        put_lane(1, ALU_SUB, 6'd21, 1'b0, 32'h0, OP_IMM, 1'b0, 6'h31);
        #1; step();
        disp.en = '0; issue_ready = 1'b1;
        #1;
        checks++; if (issue_phys_rd !== 6'h30) begin errors++; $display("FAIL age_dummy got %0h exp 30", issue_phys_rd); end
        step();
        issue_ready = 1'b0; disp.en = 2'b01;
        put_lane(0, ALU_SLT, 6'd22, 1'b0, 32'h0, OP_IMM, 1'b0, 6'h32);
        #1; step();
        disp.en = '0; wb_valid = 2'b11; wb_phys_rd[0] = 6'd21; wb_phys_rd[1] = 6'd22;
        #1; step();
        wb_valid = '0; issue_ready = 1'b1;
        #1;
        checks++; if (issue_phys_rd !== exp_first) begin errors++; $display("FAIL age_first got %0h exp %0h", issue_phys_rd, exp_first); end
        step();
        #1;
        checks++; if (issue_phys_rd !== exp_second) begin errors++; $display("FAIL age_second got %0h exp %0h", issue_phys_rd, exp_second); end
        step();
        #1;
        checks++; if (issue_valid !== 1'b0) begin errors++; $display("FAIL age_empty got %b exp 0", issue_valid); end
        issue_ready = 1'b0;
    endtask

    task automatic test_random();
        int p;
        clear_in();
        for (int c = 0; c < 600; c++) begin
            rst   = ($urandom_range(0, 127) == 0);
            flush = ($urandom_range(0, 39) == 0);
            for (int l = 0; l < DW; l++) begin
                disp.en[l] = !m_full() && ($urandom_range(0, 2) != 0);
                put_lane(l, alu_cmd_t'(4'($urandom_range(0, 9))), 6'($urandom_range(0, 15)),
                         ($urandom_range(0, 2) == 0), $urandom,
                         ($urandom_range(0, 1) == 0) ? OP_REG : OP_IMM,
                         ($urandom_range(0, 2) == 0), 6'($urandom_range(0, 63)));
            end
            for (int w = 0; w < W; w++) begin
                wb_valid[w]   = ($urandom_range(0, 1) == 1);
                wb_phys_rd[w] = 6'($urandom_range(0, 15));
            end
            issue_ready = ($urandom_range(0, 3) != 0);
            #1;
            checks++; if (issue_valid !== m_issue_valid()) begin errors++; $display("FAIL rnd_valid c=%0d got %b exp %b", c, issue_valid, m_issue_valid()); end
            checks++; if (disp.full !== m_full()) begin errors++; $display("FAIL rnd_full c=%0d got %b exp %b", c, disp.full, m_full()); end
            p = m_pick();
            if (m_issue_valid()) begin
                checks++;
                if (issue_op1 !== m_t1[p] || issue_op2 !== m_op2[p] || issue_alu_cmd !== m_cmd[p] ||
                    issue_op2_type !== m_ty[p] || issue_phys_rd !== m_rd[p])
                begin
                    errors++;
                    $display("FAIL rnd_payload c=%0d got op1=%0h op2=%0h rd=%0h exp op1=%0h op2=%0h rd=%0h",
                             c, issue_op1, issue_op2, issue_phys_rd, m_t1[p], m_op2[p], m_rd[p]);
                end
            end
            step();
        end
        clear_in();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_imm();
        test_wakeup();
        test_dispatch_wakeup();
        test_full();
        test_flush();
        test_age();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/issue_queue.md
Name: issue_queue

Overview:
- Receiving end of the rename→issue dispatch interface; consumes the `in` modport of isqDispatchIf.
- Buffers up to ISQ_DEPTH dispatched ALU ops and tracks operand readiness.
- Wakes operands on writeback tag broadcasts and issues one ready op per cycle to the ALU through a valid/ready handshake.

Parameters:
- ISQ_DEPTH, 8, number of entries; must be ≥ DISPATCH_WIDTH.
- WB_WIDTH, 2, number of writeback broadcast ports.
- DISPATCH_WIDTH and PHYS_REGS_ADDR_WIDTH are taken from package parameters and are not overridden here.

Ports:
- clk  input  1  core clock.
- rst  input  1  synchronous, active-high reset.
- dispatch  isqDispatchIf.in  -  en/alu_cmd/op1_valid/op2_valid/op1/op2/op2_type/phys_rd per lane; full driven back.
- flush  input  1  discard all entries.
- wb_valid  input  [WB_WIDTH]  writeback broadcast valid.
- wb_phys_rd  input  PHYS_REGS_ADDR_WIDTH x WB_WIDTH  writeback destination tag.
- issue_valid  output  1  selected entry is ready.
- issue_ready  input  1  ALU accepts this cycle.
- issue_alu_cmd  output  common::alu_cmd_t  selected op.
- issue_op1  output  PHYS_REGS_ADDR_WIDTH  op1 tag.
- issue_op2  output  32  op2 tag or immediate.
- issue_op2_type  output  common::op_type_t  op2 kind.
- issue_phys_rd  output  PHYS_REGS_ADDR_WIDTH  destination tag.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous and active-high.
- Reset values: all entry valid bits 0; full=0; issue_valid=0; issue_* payload outputs 0.
- Entry contents: valid, alu_cmd, op1, op1_rdy, op2, op2_type, op2_rdy, phys_rd.
  - op2 is a register operand only when op2_type is the register encoding of common::op_type_t; its tag is op2[PHYS_REGS_ADDR_WIDTH-1:0].
  - For immediates, op2_rdy is stored as 1.
- full: combinational from registered state. full = (free entries < DISPATCH_WIDTH). Entries leaving this cycle are not counted as free.
- Dispatch:
  - Lane i is written when en[i] && !full.
  - Enabled lanes go into the lowest-index free entries, in lane order.
  - en asserted while full is ignored and flagged by a simulation assertion.
  - Lanes may be sparse, e.g. en[0]=0, en[1]=1.
- Dispatch-cycle wakeup: if an incoming op1 or op2 tag matches any valid wb_phys_rd in the same cycle, the corresponding rdy bit is stored as 1.
- Wakeup of held entries: any entry operand with rdy=0 whose tag equals a valid wb_phys_rd sets rdy=1 at the next edge. Multiple matches are harmless.
- Ready condition: ready = valid && op1_rdy && op2_rdy, evaluated on registered state.
  - A wakeup in cycle N makes the entry eligible in N+1.
  - A dispatch in cycle N is eligible in N+1 at the earliest.
- Select (combinational): issue_valid = any entry ready. The payload reflects the selected entry.
  - Default policy: lowest ready index.
- Handshake:
  - On issue_valid && issue_ready, the selected entry's valid clears at the edge and the slot is reusable from the next cycle.
  - The payload is not held stable while stalled; selection may change if another entry becomes preferred. The consumer samples only on handshake.
- Flush:
  - All valid bits clear at the edge.
  - issue_valid is forced 0 in the flush cycle.
  - Dispatch in the flush cycle is dropped.
  - Flush has priority over dispatch, wakeup and issue.
- Simultaneous issue and dispatch to the same slot cannot occur, because full ignores freeing slots.
- Reset mid-operation behaves as flush plus reset of outputs.

Optional Feature:
- Macro: ISQ_AGE_SELECT_EN.
- Defined:
  - An ISQ_DEPTH x ISQ_DEPTH age matrix records relative order; select picks the oldest ready entry.
  - Same-cycle dispatched lanes: lower lane is older.
  - A dispatched entry is younger than all existing entries.
  - Issue and flush clear the matrix row and column.
- Undefined: no age matrix; lowest-index ready entry is selected.

Decomposition:
- parameters package: ISQ_DEPTH and WB_WIDTH defaults, alongside DISPATCH_WIDTH.
- common package: isq_entry_t packed struct (fields above).
- Sub-module isq_select:
  - inputs: ready vector, plus the age matrix when ISQ_AGE_SELECT_EN is defined;
  - outputs: one-hot grant and grant_valid.
  - Purely combinational; shared with future issue queues.

Test Plan:
- Reset, then dispatch lane0 {op1=5, op1_valid=1, imm op2=0x10}. Expect issue_valid=1 the next cycle with op2=0x10; with issue_ready=1, expect the queue empty the following cycle.
- Dispatch entry with op1=7, op1_valid=0; wb_valid[0]=1, wb_phys_rd=7 two cycles later. Expect issue_valid=0 until the cycle after the broadcast, then 1.
- Dispatch with op1=9, op1_valid=0 in the same cycle as wb_phys_rd[1]=9. Expect the entry issues the next cycle with no further broadcast.
- Fill 8 entries with unready ops, DISPATCH_WIDTH=2. Expect full=1 once 7 are occupied. en asserted while full writes nothing. Wake one entry and issue it; expect full=1 in the issue cycle and 0 the cycle after.
- Hold issue_ready=0 with 3 ready entries, then assert flush. Expect issue_valid=0 in the flush cycle; next cycle all entries invalid, full=0.
- ISQ_AGE_SELECT_EN: dispatch A into slot 0, B into slot 1, issue a dummy so slot 0 frees, then dispatch C into slot 0; make B and C ready together. Expect B issued before C. Without the macro, C is issued first.
